hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It drives the stall and flush controls of the PC, IF/ID and ID/EX pipeline registers from load-use, control-redirect, instruction-fetch-wait and data-memory-busy conditions, with a fixed priority. A small FSM sequences multi-cycle flushes and full-pipeline freezes. Saturating performance counters record stall cycles and redirect events.

## Interface
- FLUSH_EXTRA, default 1: extra cycles IF/ID stays flushed after a redirect, to cover instruction-memory latency (0..7).
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  the ID instruction actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  the EX instruction is a load.
- ex_redirect  in  1  branch mispredict or jump resolved in EX.
- imem_ready  in  1  instruction fetch data valid this cycle.
- dmem_busy  in  1  data memory is mid-transaction; the pipeline must freeze.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold IF/ID; drives `feedforward_stall`.
- ifid_flush  out  1  load NOP (32'h00000013) into IF/ID; drives `checkpre_flush`.
- idex_flush  out  1  insert a bubble into ID/EX.
- exmem_stall  out  1  hold EX/MEM and later stages.
- stall_cycles  out  32  count of cycles with pc_stall=1; saturates at 32'hFFFFFFFF.
- redirect_count  out  16  count of accepted redirects; saturates at 16'hFFFF.

## Operation
- FSM states:
  - RUN: normal operation.
  - FLUSH: post-redirect drain.
  - FREEZE: data memory busy.
- Load-use hazard (`lu`) = ex_memread & (ex_rd≠0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Condition priority, highest first: reset > dmem_busy > ex_redirect > FLUSH-state drain > lu > !imem_ready.
- While rst_n=0:
  - ifid_flush=1 and idex_flush=1.
  - All stalls are 0.
  - State = RUN; counters = 0.
- dmem_busy=1, in any state:
  - pc_stall, ifid_stall and exmem_stall are 1; both flushes are 0.
  - Next state is FREEZE.
  - The FLUSH down-counter holds its value, and the return state (RUN or FLUSH) is saved.
- FREEZE with dmem_busy=0: return to the saved state; outputs are evaluated normally in that same cycle.
- ex_redirect=1 (not frozen):
  - ifid_flush=1 and idex_flush=1; stalls are 0.
  - redirect_count increments.
  - If FLUSH_EXTRA>0: next state is FLUSH, with the counter loaded to FLUSH_EXTRA. Otherwise stay in RUN.
  - A redirect arriving while in FLUSH reloads the counter.
- FLUSH with no redirect:
  - ifid_flush=1; all other outputs are 0.
  - The counter decrements; at 1, the next state is RUN.
- lu in RUN:
  - pc_stall=1, ifid_stall=1, idex_flush=1.
  - Lasts one cycle; the bubble clears ex_memread next cycle.
- !imem_ready in RUN, with no lu:
  - pc_stall=1 and ifid_flush=1 (the IF/ID register receives a NOP).
  - ifid_stall=0.
- lu and a redirect in the same cycle: the redirect wins and lu is ignored, because the ID instruction is squashed.

## Timing
- All outputs are combinational from the current state and inputs, in the same cycle. There are no registered outputs, so a stall takes effect at the same edge the hazard is seen.
- The state register and counters update on the rising edge of clk.
- Redirect-to-fetch-resume latency is 1 + FLUSH_EXTRA cycles.
- stall_cycles increments on every edge where pc_stall=1 and rst_n=1, including FREEZE cycles.
- A reset asserted mid-FLUSH or mid-FREEZE returns the block to RUN on the next edge; both counters clear.

## Structure
- Shared package `riscv_pkg` holds:
  - the state enum (RUN, FLUSH, FREEZE);
  - NOP_INSTR = 32'h00000013;
  - REG_IDX_W = 5.
- One natural sub-module, `perf_sat_cnt`: a parameterised-width saturating counter with an enable, instantiated twice.
- Hazard detection and the FSM stay inline in `hazard_ctrl`.

## Test plan
- Load-use:
  - Stimulus: ex_memread=1, ex_rd=5, id_rs1=5, id_rs1_used=1.
  - Expected: pc_stall=ifid_stall=idex_flush=1 for exactly one cycle; stall_cycles goes 0→1.
  - Repeat with ex_rd=0: expect no stall.
- Redirect with FLUSH_EXTRA=2:
  - Stimulus: single-cycle ex_redirect.
  - Expected: ifid_flush=1 for 3 consecutive cycles; idex_flush=1 only in the first; redirect_count=1.
- Freeze inside FLUSH:
  - Stimulus: dmem_busy=1 for 4 cycles, starting in the 2nd FLUSH cycle.
  - Expected: stalls held for 4 cycles, flushes 0. Then FLUSH resumes with 1 cycle remaining, then RUN. stall_cycles += 4.
- Simultaneous events:
  - Stimulus: lu and ex_redirect in the same cycle.
  - Expected: pc_stall=0, ifid_flush=1, idex_flush=1.
  - Stimulus: lu and !imem_ready together.
  - Expected: ifid_stall=1, ifid_flush=0.
- Saturation and reset:
  - Stimulus: preload stall_cycles to 32'hFFFFFFFE, then 3 stall cycles.
  - Expected: the counter holds at 32'hFFFFFFFF.
  - Stimulus: rst_n=0 for one edge mid-FLUSH.
  - Expected: state RUN and counters 0 next cycle; ifid_flush=1 while rst_n is low.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core: pipeline control states and
// instruction-format constants.
package riscv_pkg;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StFreeze
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned REG_IDX_W = 5;

endpackage

// File: rtl/perf_sat_cnt.sv
// Saturating up-counter with enable and synchronous active-low clear.
module perf_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {Width{1'b1}})) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush generation for PC, IF/ID and
// ID/EX, a RUN/FLUSH/FREEZE sequencer and saturating performance counters.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned FLUSH_EXTRA = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_memread,
  input  logic                 ex_redirect,
  input  logic                 imem_ready,
  input  logic                 dmem_busy,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_stall,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          redirect_count
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_EXTRA);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  state_e     eff_state;
  logic [2:0] cnt_q, cnt_d;
  logic       lu;
  logic       redirect_acc;

  assign lu = ex_memread && (ex_rd != '0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    redirect_acc = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    // Leaving FREEZE behaves exactly like being in the saved state this cycle.
    eff_state    = (state_q == StFreeze) ? ret_q : state_q;

    if (!rst_n) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = StRun;
      ret_d      = StRun;
      cnt_d      = '0;
    end else if (dmem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      exmem_stall = 1'b1;
      state_d     = StFreeze;
      ret_d       = eff_state;
    end else if (ex_redirect) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      redirect_acc = 1'b1;
      if (FLUSH_EXTRA > 0) begin
        state_d = StFlush;
        cnt_d   = FlushLoad;
      end else begin
        state_d = StRun;
      end
    end else if (eff_state == StFlush) begin
      ifid_flush = 1'b1;
      cnt_d      = cnt_q - 3'd1;
      state_d    = (cnt_q <= 3'd1) ? StRun : StFlush;
    end else begin
      state_d = StRun;
      if (lu) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end else if (!imem_ready) begin
        // Hold the PC and feed a NOP into IF/ID until fetch data arrives.
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      ret_q   <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  perf_sat_cnt #(
    .Width(32)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pc_stall),
    .cnt  (stall_cycles)
  );

  perf_sat_cnt #(
    .Width(16)
  ) u_redir_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (redirect_acc),
    .cnt  (redirect_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// against a flush-budget reference model.
module tb_hazard_ctrl;

  localparam int unsigned FE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_memread, ex_redirect, imem_ready, dmem_busy;
  logic        pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall;
  logic [31:0] stall_cycles;
  logic [15:0] redirect_count;
  logic        sat_en;
  logic [3:0]  sat_cnt;
  logic [4:0]  obs;

  int total = 0;
  int bad = 0;

  // Reference model state: remaining drain cycles and expected counter values.
  int              m_left = 0;
  longint unsigned m_sc = 0;
  int              m_rc = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .FLUSH_EXTRA(FE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_rd         (ex_rd),
    .ex_memread    (ex_memread),
    .ex_redirect   (ex_redirect),
    .imem_ready    (imem_ready),
    .dmem_busy     (dmem_busy),
    .pc_stall      (pc_stall),
    .ifid_stall    (ifid_stall),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_stall   (exmem_stall),
    .stall_cycles  (stall_cycles),
    .redirect_count(redirect_count)
  );

  perf_sat_cnt #(
    .Width(4)
  ) u_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sat_en),
    .cnt  (sat_cnt)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall}
  assign obs = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall};

  function automatic logic [4:0] model_out();
    logic lu;
    lu = ex_memread && (ex_rd != 0) &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (!rst_n) return 5'b00110;
    if (dmem_busy) return 5'b11001;
    if (ex_redirect) return 5'b00110;
    if (m_left > 0) return 5'b00100;
    if (lu) return 5'b11010;
    if (!imem_ready) return 5'b10100;
    return 5'b00000;
  endfunction

  always @(posedge clk) begin : model
    logic [4:0] e;
    e = model_out();
    if (!rst_n) begin
      m_left <= 0;
      m_sc   <= 0;
      m_rc   <= 0;
    end else begin
      if (e[4] && m_sc < 64'hFFFF_FFFF) m_sc <= m_sc + 1;
      if (!dmem_busy) begin
        if (ex_redirect) begin
          if (m_rc < 65535) m_rc <= m_rc + 1;
          m_left <= FE;
        end else if (m_left > 0) begin
          m_left <= m_left - 1;
        end
      end
    end
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_memread = 0;
    ex_redirect = 0; imem_ready = 1; dmem_busy = 0; sat_en = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    @(negedge clk);
    total++;
    if (obs !== 5'b00110) begin bad++; $display("FAIL reset_outs got=%b want=00110", obs); end
    advance();
    @(negedge clk);
    total++;
    if (stall_cycles !== 0 || redirect_count !== 0) begin
      bad++; $display("FAIL reset_cnts got=%0d/%0d want=0/0", stall_cycles, redirect_count);
    end
    advance();
    rst_n = 1;
  endtask

  task automatic test_load_use();
    idle();
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
    @(negedge clk);
    total++;
    if (obs !== 5'b11010) begin bad++; $display("FAIL lu_stall got=%b want=11010", obs); end
    advance();
    ex_memread = 0;
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL lu_one_cycle got=%b want=00000", obs); end
    total++;
    if (stall_cycles !== 32'd1) begin bad++; $display("FAIL lu_count got=%0d want=1", stall_cycles); end
    ex_memread = 1; ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL lu_x0 got=%b want=00000", obs); end
    advance();
    idle();
  endtask

  task automatic test_redirect();
    logic [4:0] want [4] = '{5'b00110, 5'b00100, 5'b00100, 5'b00000};
    idle();
    ex_redirect = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs !== want[i]) begin
        bad++; $display("FAIL redirect_c%0d got=%b want=%b", i, obs, want[i]);
      end
      advance();
      ex_redirect = 0;
    end
    total++;
    if (redirect_count !== 16'd1) begin
      bad++; $display("FAIL redirect_count got=%0d want=1", redirect_count);
    end
  endtask

  task automatic test_freeze_in_flush();
    idle();
    ex_redirect = 1;
    advance();
    ex_redirect = 0;
    @(negedge clk);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL frz_flush1 got=%b want=00100", obs); end
    advance();
    dmem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs !== 5'b11001) begin bad++; $display("FAIL frz_c%0d got=%b want=11001", i, obs); end
      advance();
    end
    dmem_busy = 0;
    @(negedge clk);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL frz_resume got=%b want=00100", obs); end
    advance();
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL frz_run got=%b want=00000", obs); end
    total++;
    if (stall_cycles !== 32'd5 || redirect_count !== 16'd2) begin
      bad++; $display("FAIL frz_cnts got=%0d/%0d want=5/2", stall_cycles, redirect_count);
    end
  endtask

  task automatic test_simultaneous();
    idle();
    ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1; ex_redirect = 1;
    @(negedge clk);
    total++;
    if (obs !== 5'b00110) begin bad++; $display("FAIL sim_lu_redir got=%b want=00110", obs); end
    advance();
    idle();
    advance();
    advance();
    ex_memread = 1; ex_rd = 9; id_rs1 = 9; id_rs1_used = 1; imem_ready = 0;
    @(negedge clk);
    total++;
    if (obs !== 5'b11010) begin bad++; $display("FAIL sim_lu_imem got=%b want=11010", obs); end
    advance();
    ex_memread = 0;
    @(negedge clk);
    total++;
    if (obs !== 5'b10100) begin bad++; $display("FAIL imem_wait got=%b want=10100", obs); end
    advance();
    idle();
  endtask

  task automatic test_saturation();
    int n = 0;
    idle();
    sat_en = 1;
    for (int i = 0; i < 18; i++) begin
      advance();
      if (n < 15) n++;
      if (i == 13 || i == 17) begin
        total++;
        if (sat_cnt !== 4'(n)) begin bad++; $display("FAIL sat_c%0d got=%0d want=%0d", i, sat_cnt, n); end
      end
    end
    sat_en = 0;
  endtask

  task automatic test_reset_mid_flush();
    idle();
    ex_redirect = 1;
    advance();
    ex_redirect = 0;
    rst_n = 0;
    @(negedge clk);
    total++;
    if (obs !== 5'b00110) begin bad++; $display("FAIL rst_flush_outs got=%b want=00110", obs); end
    advance();
    rst_n = 1;
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL rst_flush_run got=%b want=00000", obs); end
    total++;
    if (stall_cycles !== 0 || redirect_count !== 0) begin
      bad++; $display("FAIL rst_flush_cnts got=%0d/%0d want=0/0", stall_cycles, redirect_count);
    end
    advance();
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      dmem_busy   = ($urandom_range(0, 6) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      imem_ready  = ($urandom_range(0, 4) != 0);
      ex_memread  = $urandom_range(0, 1) == 1;
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs1_used = $urandom_range(0, 1) == 1;
      id_rs2_used = $urandom_range(0, 1) == 1;
      @(negedge clk);
      e = model_out();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rnd_outs i=%0d got=%b want=%b", i, obs, e); end
      total++;
      if (stall_cycles !== m_sc[31:0]) begin
        bad++; $display("FAIL rnd_stall_cnt i=%0d got=%0d want=%0d", i, stall_cycles, m_sc);
      end
      total++;
      if (redirect_count !== 16'(m_rc)) begin
        bad++; $display("FAIL rnd_redir_cnt i=%0d got=%0d want=%0d", i, redirect_count, m_rc);
      end
      advance();
    end
    rst_n = 1;
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_freeze_in_flush();
    test_simultaneous();
    test_saturation();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
